// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned N_REQ_DEFAULT  = 4;
  localparam int unsigned TIMEOUT_CYCLES = 4;
  localparam int unsigned TIMER_W        = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: searches upward from last+1, wrapping at N-1.
module uart_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic         found;
  int unsigned  cand;
  logic [N-1:0] rot;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    rot   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last) + i) % N;
      rot  = req >> cand;
      if (!found && rot[0]) begin
        found = 1'b1;
        grant = {{(N-1){1'b0}}, 1'b1} << cand;
        idx   = IW'(cand);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding bytes from N_REQ requesters into one UART transmitter.
// Define UART_TX_ARB_LOCK_EN to hold the grant on one requester until its req_last byte.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     active
);

  localparam int unsigned OW = $clog2(N_REQ);

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [N_REQ-1:0]   eligible;
  logic [N_REQ-1:0]   pick_grant;
  logic [OW-1:0]      pick_idx;
  logic               pick_any;
  logic [7:0]         pick_data;
  logic               grant_en;

`ifdef UART_TX_ARB_LOCK_EN
  logic lock;
  logic pick_last;

  assign pick_last = 1'(req_last >> pick_idx);

  // While locked, only the requester that opened the frame (held in owner) may win.
  assign eligible = lock ? (req_valid & ({{(N_REQ-1){1'b0}}, 1'b1} << owner)) : req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock <= 1'b0;
    end else if (grant_en) begin
      lock <= ~pick_last;
    end
  end
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  uart_rr_pick #(.N(N_REQ)) u_pick (
    .req   (eligible),
    .last  (owner),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign pick_data = 8'(req_data >> (8 * 32'(pick_idx)));

  // Next-state and grant decode; ready is gated by rst_n so it stays low during reset.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    req_ready = '0;
    grant_en  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && !tx_busy && pick_any) begin
          grant_en  = 1'b1;
          req_ready = pick_grant;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          state_n = IDLE;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      owner    <= OW'(N_REQ - 1);
      active   <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      tx_start <= grant_en;
      active   <= (state_n != IDLE);
      if (grant_en) begin
        tx_data <= pick_data;
        owner   <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb (N_REQ = 4); lock scenario depends on UART_TX_ARB_LOCK_EN.
module tb_uart_tx_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  owner;
  logic        active;

  int checks = 0;
  int errors = 0;

  uart_tx_arb #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .owner     (owner),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[8*i +: 8] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full handshake from an IDLE grant through WAIT_DONE back to IDLE.
  task automatic serve(input int w, input logic [7:0] b, input bit clr, input string tag);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'(1) << w);
    tick();
    if (clr) req_valid[w] = 1'b0;
    chk({tag, "_start"}, 32'(tx_start), 32'd1);
    chk({tag, "_data"}, 32'(tx_data), 32'(b));
    chk({tag, "_owner"}, 32'(owner), 32'(w));
    chk({tag, "_rdy_lo"}, 32'(req_ready), 32'd0);
    tick();
    chk({tag, "_start_lo"}, 32'(tx_start), 32'd0);
    tx_busy = 1'b1;
    tick();
    tick();
    chk({tag, "_busy_rdy"}, 32'(req_ready), 32'd0);
    chk({tag, "_busy_act"}, 32'(active), 32'd1);
    tx_busy = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'(active), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_last  = '0;
    req_data  = 32'hDEAD_BEEF;
    tx_busy   = 1'b0;
    tick();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_owner", 32'(owner), 32'd3);
    chk("rst_active", 32'(active), 32'd0);
    do_reset();

    // Single requester byte A5.
    req_valid = 4'b0001;
    set_byte(0, 8'hA5);
    serve(0, 8'hA5, 1'b1, "single");

    // Transmitter busy in IDLE blocks any grant.
    req_valid = 4'b0010;
    set_byte(1, 8'h31);
    tx_busy   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_hold_ready", 32'(req_ready), 32'd0);
      chk("busy_hold_start", 32'(tx_start), 32'd0);
      tick();
    end
    tx_busy = 1'b0;
    serve(1, 8'h31, 1'b1, "busy_release");

    // Lost start: tx_busy never rises, four WAIT_BUSY cycles then IDLE.
    req_valid = 4'b0100;
    set_byte(2, 8'h42);
    #1;
    chk("lost_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    chk("lost_start", 32'(tx_start), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lost_wait_act", 32'(active), 32'd1);
      chk("lost_wait_start", 32'(tx_start), 32'd0);
    end
    tick();
    chk("lost_idle", 32'(active), 32'd0);
    req_valid = 4'b1000;
    set_byte(3, 8'h53);
    serve(3, 8'h53, 1'b1, "after_lost");

    // All four valid after reset: strict rotation 0,1,2,3,0.
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h1312_1110;
    serve(0, 8'h10, 1'b0, "rr0");
    serve(1, 8'h11, 1'b0, "rr1");
    serve(2, 8'h12, 1'b0, "rr2");
    serve(3, 8'h13, 1'b0, "rr3");
    serve(0, 8'h10, 1'b1, "rr4");

    // Frame from requester 2 with requester 0 also waiting.
    do_reset();
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    set_byte(0, 8'h05);
    set_byte(2, 8'h20);
    serve(2, 8'h20, 1'b0, "frame_b0");
    req_valid = 4'b0101;
    set_byte(2, 8'h21);
`ifdef UART_TX_ARB_LOCK_EN
    serve(2, 8'h21, 1'b0, "lock_b1");
    set_byte(2, 8'h22);
    req_last = 4'b0100;
    serve(2, 8'h22, 1'b1, "lock_b2");
    serve(0, 8'h05, 1'b1, "lock_r0");
`else
    serve(0, 8'h05, 1'b1, "nolock_r0");
    serve(2, 8'h21, 1'b1, "nolock_b1");
`endif

    // Reset asserted in WAIT_DONE.
    req_valid = 4'b0010;
    req_last  = '0;
    set_byte(1, 8'h77);
    #1;
    chk("mid_ready", 32'(req_ready), 32'h2);
    tick();
    tick();
    tx_busy = 1'b1;
    tick();
    tick();
    chk("mid_active", 32'(active), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'h00);
    chk("mid_rst_owner", 32'(owner), 32'd3);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 4'b0000;
    tx_busy   = 1'b0;
    rst_n     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_start", 32'(tx_start), 32'd0);
      chk("post_rst_active", 32'(active), 32'd0);
    end
    req_valid = 4'b0011;
    set_byte(0, 8'h99);
    serve(0, 8'h99, 1'b1, "post_rst_r0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
